// File: rtl/lsu_pkg.sv
// Shared state type, funct3 encodings and the request legality rule
// for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // True only for exactly one of load/store, a size valid for that direction,
  // and an address naturally aligned to that size.
  function automatic logic access_legal(input logic       mem_read,
                                        input logic       mem_write,
                                        input logic [2:0] funct3,
                                        input logic [1:0] addr_lo);
    logic size_ok;
    logic align_ok;
    case (funct3)
      F3_B, F3_H, F3_W: size_ok = 1'b1;
      F3_BU, F3_HU:     size_ok = mem_read;
      default:          size_ok = 1'b0;
    endcase
    case (funct3[1:0])
      2'b01:   align_ok = ~addr_lo[0];
      2'b10:   align_ok = (addr_lo == 2'b00);
      default: align_ok = 1'b1;
    endcase
    return (mem_read ^ mem_write) & size_ok & align_ok;
  endfunction

endpackage

// File: rtl/lsu_load_format.sv
// Selects the addressed byte/halfword lane of a bus read word and applies
// sign or zero extension according to the load funct3.
module lsu_load_format
  import lsu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0] i_rdata,
  input  logic [1:0]   i_addr_lo,
  input  logic [2:0]   i_funct3,
  output logic [N-1:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // NOTE: every output of a combinational block gets a value on every path
  // (defaults or full case coverage), otherwise synthesis infers a latch.
  always_comb begin
    case (i_addr_lo)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

    case (i_funct3)
      F3_B:    o_data = {{(N-8){w_byte[7]}}, w_byte};
      F3_BU:   o_data = {{(N-8){1'b0}}, w_byte};
      F3_H:    o_data = {{(N-16){w_half[15]}}, w_half};
      F3_HU:   o_data = {{(N-16){1'b0}}, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory access stage: turns a core load/store into a valid/ready word-bus
// transaction with lane steering, core stall generation and fault reporting.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int N       = 32,
  parameter int TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         MemRead,
  input  logic         MemWrite,
  input  logic [2:0]   funct3,
  input  logic [N-1:0] ALUResult,
  input  logic [N-1:0] WriteData,
  output logic [N-1:0] ReadData,
  output logic         Stall,
  output logic         AccessFault,
  output logic         BusFault,
  output logic         bus_valid,
  output logic         bus_we,
  output logic [N-1:0] bus_addr,
  output logic [N-1:0] bus_wdata,
  output logic [3:0]   bus_wstrb,
  input  logic         bus_ready,
  input  logic [N-1:0] bus_rdata
);

  localparam logic [7:0] CNT_LIMIT = 8'(TIMEOUT - 1);

  lsu_state_e   r_state;
  lsu_state_e   w_next_state;
  logic [7:0]   r_cnt;
  logic         r_bus_valid;
  logic         r_bus_we;
  logic         r_bus_fault;
  logic         r_is_load;
  logic [N-1:0] r_bus_addr;
  logic [N-1:0] r_bus_wdata;
  logic [N-1:0] r_read_data;
  logic [3:0]   r_bus_wstrb;
  logic [2:0]   r_funct3;
  logic [1:0]   r_addr_lo;

  logic         w_req;
  logic         w_legal;
  logic         w_launch;
  logic         w_timeout;
  logic         w_stall;
  logic         w_access_fault;
  logic [N-1:0] w_wdata;
  logic [N-1:0] w_load_data;
  logic [3:0]   w_wstrb;

  assign w_req     = MemRead | MemWrite;
  assign w_legal   = access_legal(MemRead, MemWrite, funct3, ALUResult[1:0]);
  assign w_launch  = (r_state == IDLE) && w_legal;
  assign w_timeout = (r_cnt == CNT_LIMIT);

  always_comb begin
    w_wdata = WriteData;
    w_wstrb = 4'b1111;
    case (funct3)
      F3_B: begin
        w_wdata = {4{WriteData[7:0]}};
        w_wstrb = 4'b0001 << ALUResult[1:0];
      end
      F3_H: begin
        w_wdata = {2{WriteData[15:0]}};
        w_wstrb = ALUResult[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  // Lane/size are captured at launch so formatting does not depend on the
  // core holding its inputs perfectly steady through the bus phase.
  lsu_load_format #(.N(N)) u_load_format (
    .i_rdata   (bus_rdata),
    .i_addr_lo (r_addr_lo),
    .i_funct3  (r_funct3),
    .o_data    (w_load_data)
  );

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking (=) here creates simulation/synthesis races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state   = r_state;
    w_stall        = 1'b0;
    w_access_fault = 1'b0;
    case (r_state)
      IDLE: begin
        w_access_fault = w_req & ~w_legal;
        if (w_launch) begin
          w_stall      = 1'b1;
          w_next_state = BUS;
        end
      end
      BUS: begin
        w_stall = 1'b1;
        if (bus_ready || w_timeout) w_next_state = DONE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Qualified by rst_n so the core is released the instant reset asserts,
  // even while a legal request is still being presented.
  assign Stall       = w_stall & rst_n;
  assign AccessFault = w_access_fault & rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_bus_valid <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_bus_wstrb <= '0;
      r_bus_fault <= 1'b0;
      r_is_load   <= 1'b0;
      r_funct3    <= '0;
      r_addr_lo   <= '0;
      r_read_data <= '0;
    end else begin
      r_bus_fault <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_launch) begin
            r_bus_valid <= 1'b1;
            r_bus_we    <= MemWrite;
            r_bus_addr  <= {ALUResult[N-1:2], 2'b00};
            r_bus_wdata <= w_wdata;
            r_bus_wstrb <= MemWrite ? w_wstrb : 4'b0000;
            r_cnt       <= '0;
            r_is_load   <= MemRead;
            r_funct3    <= funct3;
            r_addr_lo   <= ALUResult[1:0];
          end
        end
        BUS: begin
          if (bus_ready) begin
            r_bus_valid <= 1'b0;
            r_bus_wstrb <= '0;
            if (r_is_load) r_read_data <= w_load_data;
          end else if (w_timeout) begin
            r_bus_valid <= 1'b0;
            r_bus_wstrb <= '0;
            r_bus_fault <= 1'b1;
            if (r_is_load) r_read_data <= '0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign ReadData  = r_read_data;
  assign BusFault  = r_bus_fault;
  assign bus_valid = r_bus_valid;
  assign bus_we    = r_bus_we;
  assign bus_addr  = r_bus_addr;
  assign bus_wdata = r_bus_wdata;
  assign bus_wstrb = r_bus_wstrb;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus randomized
// accesses checked against a behavioural model of the access rules.
module tb_load_store_unit;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] ALUResult = '0;
  logic [31:0] WriteData = '0;
  logic        bus_ready = 1'b0;
  logic [31:0] bus_rdata = '0;
  logic [31:0] ReadData;
  logic        Stall, AccessFault, BusFault, bus_valid, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;

  int n_cmp = 0;
  int n_mis = 0;
  logic [31:0] exp_rd = '0;

  typedef struct {
    logic        req_stall;
    logic        req_afault;
    int          stall_cycles;
    int          valid_cycles;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        we;
    logic        unstable;
    logic        done_stall;
    logic        done_bfault;
    logic        done_afault;
    logic        done_valid;
    logic [3:0]  done_wstrb;
    logic [31:0] done_rdata;
    logic        after_valid;
  } obs_t;

  load_store_unit #(.N(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .MemRead(MemRead), .MemWrite(MemWrite),
    .funct3(funct3), .ALUResult(ALUResult), .WriteData(WriteData),
    .ReadData(ReadData), .Stall(Stall), .AccessFault(AccessFault),
    .BusFault(BusFault), .bus_valid(bus_valid), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
    .bus_ready(bus_ready), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic m_legal(input logic rd, input logic wr,
                                   input logic [2:0] f3, input logic [31:0] addr);
    int size;
    if (rd == wr) return 1'b0;
    if (wr && !(f3 inside {3'd0, 3'd1, 3'd2})) return 1'b0;
    if (rd && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b0;
    size = 1 << f3[1:0];
    return (addr % size) == 0;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr,
                                         input logic [31:0] word);
    int unsigned off, b, h;
    off = addr % 4;
    b = (word >> (8 * off)) & 32'hFF;
    h = (word >> (16 * (off / 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
    case (f3)
      3'd0:    return (wd & 32'hFF) * 32'h0101_0101;
      3'd1:    return (wd & 32'hFFFF) * 32'h0001_0001;
      default: return wd;
    endcase
  endfunction

  function automatic logic [3:0] m_wstrb(input logic [2:0] f3, input logic [31:0] addr);
    case (f3)
      3'd0:    return 4'(1 << (addr % 4));
      3'd1:    return ((addr % 4) >= 2) ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Presents one request (entered #1 after a rising edge with DUT idle), acts as
  // the bus slave raising bus_ready on BUS cycle ready_idx (-1 = never), and
  // records what the DUT showed. Leaves the bench #1 after a rising edge, idle.
  task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] rword, input int ready_idx,
                           output obs_t o);
    int cyc;
    o = '{default: 0};
    MemRead = rd; MemWrite = wr; funct3 = f3; ALUResult = addr; WriteData = wd;
    bus_ready = 1'b0;
    @(negedge clk);
    o.req_stall = Stall;
    o.req_afault = AccessFault;
    if (Stall) o.stall_cycles++;
    @(posedge clk); #1;
    cyc = 0;
    while (bus_valid && cyc < 300) begin
      if (cyc == ready_idx) begin bus_ready = 1'b1; bus_rdata = rword; end
      else begin bus_ready = 1'b0; bus_rdata = $urandom; end
      @(negedge clk);
      if (cyc == 0) begin
        o.addr = bus_addr; o.wdata = bus_wdata; o.wstrb = bus_wstrb; o.we = bus_we;
      end else if (o.addr !== bus_addr || o.wdata !== bus_wdata ||
                   o.wstrb !== bus_wstrb || o.we !== bus_we) begin
        o.unstable = 1'b1;
      end
      if (Stall) o.stall_cycles++;
      o.valid_cycles++;
      @(posedge clk); #1;
      cyc++;
    end
    bus_ready = 1'b0;
    @(negedge clk);
    o.done_stall = Stall; o.done_bfault = BusFault; o.done_afault = AccessFault;
    o.done_valid = bus_valid; o.done_wstrb = bus_wstrb; o.done_rdata = ReadData;
    @(posedge clk); #1;
    MemRead = 1'b0; MemWrite = 1'b0;
    @(negedge clk);
    o.after_valid = bus_valid;
    @(posedge clk); #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    MemRead = 1'b1; funct3 = 3'd2; ALUResult = 32'h40;
    @(negedge clk);
    n_cmp++; if (Stall !== 1'b0) begin n_mis++; $display("FAIL reset_stall: got %b want 0", Stall); end
    n_cmp++; if (AccessFault !== 1'b0) begin n_mis++; $display("FAIL reset_afault: got %b want 0", AccessFault); end
    n_cmp++; if (ReadData !== 32'h0) begin n_mis++; $display("FAIL reset_rdata: got %h want 0", ReadData); end
    n_cmp++; if (bus_valid !== 1'b0 || bus_we !== 1'b0) begin n_mis++; $display("FAIL reset_valid_we: got %b%b want 00", bus_valid, bus_we); end
    n_cmp++; if (bus_addr !== 32'h0 || bus_wdata !== 32'h0 || bus_wstrb !== 4'h0) begin
      n_mis++; $display("FAIL reset_bus: got addr %h wdata %h wstrb %b want zeros", bus_addr, bus_wdata, bus_wstrb); end
    n_cmp++; if (BusFault !== 1'b0) begin n_mis++; $display("FAIL reset_bfault: got %b want 0", BusFault); end
    MemRead = 1'b0;
    rst_n = 1'b1;
    exp_rd = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_loads();
    obs_t o;
    do_access(1, 0, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 2, o);
    n_cmp++; if (o.stall_cycles !== 4) begin n_mis++; $display("FAIL lw_stall_cycles: got %0d want 4", o.stall_cycles); end
    n_cmp++; if (o.valid_cycles !== 3) begin n_mis++; $display("FAIL lw_valid_cycles: got %0d want 3", o.valid_cycles); end
    n_cmp++; if (o.addr !== 32'h100 || o.we !== 1'b0 || o.wstrb !== 4'b0000) begin
      n_mis++; $display("FAIL lw_bus: got addr %h we %b wstrb %b want 100 0 0000", o.addr, o.we, o.wstrb); end
    n_cmp++; if (o.done_rdata !== 32'hDEADBEEF || o.done_stall !== 1'b0) begin
      n_mis++; $display("FAIL lw_done: got rdata %h stall %b want deadbeef 0", o.done_rdata, o.done_stall); end
    n_cmp++; if (o.after_valid !== 1'b0) begin n_mis++; $display("FAIL lw_relaunch: got valid %b want 0", o.after_valid); end
    do_access(1, 0, 3'd0, 32'h103, 32'h0, 32'h80112233, 0, o);
    n_cmp++; if (o.done_rdata !== 32'hFFFFFF80) begin n_mis++; $display("FAIL lb: got %h want ffffff80", o.done_rdata); end
    do_access(1, 0, 3'd4, 32'h103, 32'h0, 32'h80112233, 1, o);
    n_cmp++; if (o.done_rdata !== 32'h00000080) begin n_mis++; $display("FAIL lbu: got %h want 00000080", o.done_rdata); end
    do_access(1, 0, 3'd5, 32'h102, 32'h0, 32'h80112233, 0, o);
    n_cmp++; if (o.done_rdata !== 32'h00008011) begin n_mis++; $display("FAIL lhu: got %h want 00008011", o.done_rdata); end
    exp_rd = 32'h00008011;
  endtask

  task automatic test_stores();
    obs_t o;
    do_access(0, 1, 3'd0, 32'h201, 32'h000000A5, 32'h0, 1, o);
    n_cmp++; if (o.addr !== 32'h200 || o.wdata !== 32'hA5A5A5A5 || o.wstrb !== 4'b0010 || o.we !== 1'b1) begin
      n_mis++; $display("FAIL sb_bus: got addr %h wdata %h wstrb %b we %b want 200 a5a5a5a5 0010 1", o.addr, o.wdata, o.wstrb, o.we); end
    n_cmp++; if (o.unstable !== 1'b0) begin n_mis++; $display("FAIL sb_hold: bus fields changed while waiting"); end
    n_cmp++; if (o.done_wstrb !== 4'b0000 || o.done_valid !== 1'b0) begin
      n_mis++; $display("FAIL sb_done_bus: got wstrb %b valid %b want 0000 0", o.done_wstrb, o.done_valid); end
    do_access(0, 1, 3'd1, 32'h202, 32'h1234BEEF, 32'h0, 3, o);
    n_cmp++; if (o.wstrb !== 4'b1100 || o.wdata !== 32'hBEEFBEEF) begin
      n_mis++; $display("FAIL sh_bus: got wstrb %b wdata %h want 1100 beefbeef", o.wstrb, o.wdata); end
    n_cmp++; if (o.done_rdata !== exp_rd) begin n_mis++; $display("FAIL store_keeps_rdata: got %h want %h", o.done_rdata, exp_rd); end
  endtask

  task automatic test_access_fault();
    obs_t o;
    logic [1:0]  rw [5]  = '{2'b10, 2'b01, 2'b11, 2'b01, 2'b10};
    logic [2:0]  f3s [5] = '{3'd2, 3'd1, 3'd2, 3'd4, 3'd3};
    logic [31:0] adr [5] = '{32'h102, 32'h101, 32'h100, 32'h100, 32'h100};
    for (int i = 0; i < 5; i++) begin
      do_access(rw[i][1], rw[i][0], f3s[i], adr[i], 32'h55, 32'h77, 0, o);
      n_cmp++; if (o.req_afault !== 1'b1 || o.req_stall !== 1'b0) begin
        n_mis++; $display("FAIL afault_%0d: got fault %b stall %b want 1 0", i, o.req_afault, o.req_stall); end
      n_cmp++; if (o.valid_cycles !== 0 || o.done_rdata !== exp_rd) begin
        n_mis++; $display("FAIL afault_nobus_%0d: got valid_cycles %0d rdata %h want 0 %h", i, o.valid_cycles, o.done_rdata, exp_rd); end
    end
  endtask

  task automatic test_timeout();
    obs_t o;
    do_access(1, 0, 3'd2, 32'h400, 32'h0, 32'h0, -1, o);
    n_cmp++; if (o.valid_cycles !== TO) begin n_mis++; $display("FAIL to_valid_cycles: got %0d want %0d", o.valid_cycles, TO); end
    n_cmp++; if (o.done_bfault !== 1'b1 || o.done_afault !== 1'b0) begin
      n_mis++; $display("FAIL to_fault: got bus %b access %b want 1 0", o.done_bfault, o.done_afault); end
    n_cmp++; if (o.done_rdata !== 32'h0) begin n_mis++; $display("FAIL to_rdata: got %h want 0", o.done_rdata); end
    @(negedge clk);
    n_cmp++; if (BusFault !== 1'b0) begin n_mis++; $display("FAIL to_pulse_width: got %b want 0", BusFault); end
    @(posedge clk); #1;
    do_access(1, 0, 3'd2, 32'h404, 32'h0, 32'hCAFEF00D, TO - 1, o);
    n_cmp++; if (o.valid_cycles !== TO || o.done_bfault !== 1'b0 || o.done_rdata !== 32'hCAFEF00D) begin
      n_mis++; $display("FAIL to_edge_ready: got cycles %0d fault %b rdata %h want %0d 0 cafef00d",
                        o.valid_cycles, o.done_bfault, o.done_rdata, TO); end
    exp_rd = 32'hCAFEF00D;
  endtask

  task automatic test_reset_mid();
    obs_t o;
    MemRead = 1'b1; MemWrite = 1'b0; funct3 = 3'd2; ALUResult = 32'h300;
    @(posedge clk); #1;
    @(posedge clk); #2;
    n_cmp++; if (bus_valid !== 1'b1 || Stall !== 1'b1) begin
      n_mis++; $display("FAIL rst_mid_pre: got valid %b stall %b want 1 1", bus_valid, Stall); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus_valid !== 1'b0 || Stall !== 1'b0 || ReadData !== 32'h0) begin
      n_mis++; $display("FAIL rst_mid_async: got valid %b stall %b rdata %h want 0 0 0", bus_valid, Stall, ReadData); end
    exp_rd = '0;
    @(negedge clk);
    MemRead = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_access(1, 0, 3'd2, 32'h304, 32'h0, 32'h13579BDF, 1, o);
    n_cmp++; if (o.done_rdata !== 32'h13579BDF || o.done_bfault !== 1'b0) begin
      n_mis++; $display("FAIL rst_mid_after: got rdata %h fault %b want 13579bdf 0", o.done_rdata, o.done_bfault); end
    exp_rd = 32'h13579BDF;
  endtask

  task automatic test_random();
    obs_t o;
    logic rd, wr, legal, timed_out;
    logic [2:0] f3;
    logic [31:0] addr, wd, word, exp_w;
    int sel, ridx, exp_valid;
    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 9);
      rd = (sel == 0) || (sel < 6);
      wr = (sel == 0) || (sel >= 6);
      f3 = 3'($urandom_range(0, 7));
      addr = $urandom;
      wd = $urandom;
      word = $urandom;
      ridx = ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(0, 5);
      legal = m_legal(rd, wr, f3, addr);
      do_access(rd, wr, f3, addr, wd, word, ridx, o);
      n_cmp++; if (o.req_afault !== !legal || o.req_stall !== legal) begin
        n_mis++; $display("FAIL rnd_req_%0d: got fault %b stall %b want %b %b", i, o.req_afault, o.req_stall, !legal, legal); end
      if (legal) begin
        timed_out = (ridx < 0);
        exp_valid = timed_out ? TO : ridx + 1;
        exp_w = wr ? m_wdata(f3, wd) : o.wdata;
        if (rd) exp_rd = timed_out ? 32'h0 : m_load(f3, addr, word);
        n_cmp++; if (o.valid_cycles !== exp_valid || o.stall_cycles !== exp_valid + 1) begin
          n_mis++; $display("FAIL rnd_cycles_%0d: got valid %0d stall %0d want %0d %0d", i, o.valid_cycles, o.stall_cycles, exp_valid, exp_valid + 1); end
        n_cmp++; if (o.addr !== (addr & 32'hFFFF_FFFC) || o.we !== wr || o.wstrb !== (wr ? m_wstrb(f3, addr) : 4'b0000) ||
                     o.wdata !== exp_w || o.unstable !== 1'b0) begin
          n_mis++; $display("FAIL rnd_bus_%0d: got addr %h we %b wstrb %b wdata %h unstable %b", i, o.addr, o.we, o.wstrb, o.wdata, o.unstable); end
        n_cmp++; if (o.done_bfault !== timed_out || o.done_afault !== 1'b0 || o.done_stall !== 1'b0 ||
                     o.done_valid !== 1'b0 || o.after_valid !== 1'b0) begin
          n_mis++; $display("FAIL rnd_done_%0d: got bfault %b afault %b stall %b valid %b relaunch %b want %b 0 0 0 0",
                            i, o.done_bfault, o.done_afault, o.done_stall, o.done_valid, o.after_valid, timed_out); end
      end else begin
        n_cmp++; if (o.valid_cycles !== 0) begin n_mis++; $display("FAIL rnd_illegal_bus_%0d: got %0d valid cycles want 0", i, o.valid_cycles); end
      end
      n_cmp++; if (o.done_rdata !== exp_rd) begin n_mis++; $display("FAIL rnd_rdata_%0d: got %h want %h", i, o.done_rdata, exp_rd); end
    end
  endtask

  initial begin
    test_reset();
    test_loads();
    test_stores();
    test_access_fault();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
